// File: rtl/ram_stream_reader.sv
// Streams a window of RAM words from base_addr over a valid/ready port with a last flag.
// Optional RD_CHECKSUM_EN adds a running modulo-2**DATA_W checksum of the accepted words.
module ram_stream_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef RD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(1 << ADDR_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_next_s;
  logic [LEN_W-1:0]  remaining_r;
  logic [LEN_W-1:0]  remaining_next_s;
  logic [DATA_W-1:0] data_next_s;
  logic              valid_next_s;
  logic              last_next_s;
  logic              start_accept_s;
  logic              accept_s;

  assign mem_addr       = rd_ptr_r;
  assign start_accept_s = (state_r == IDLE) && start;
  assign accept_s       = (state_r == STREAM) && out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    state_next_s     = state_r;
    rd_ptr_next_s    = rd_ptr_r;
    remaining_next_s = remaining_r;
    data_next_s      = out_data;
    valid_next_s     = out_valid;
    last_next_s      = out_last;
    case (state_r)
      IDLE: begin
        if (start_accept_s) begin
          state_next_s     = STREAM;
          rd_ptr_next_s    = base_addr;
          remaining_next_s = (length == {LEN_W{1'b0}}) ? FULL_LEN : length;
        end else begin
          state_next_s = IDLE;
        end
      end
      STREAM: begin
        // A new word may enter the output register whenever the old one is gone or leaving.
        if ((remaining_r != {LEN_W{1'b0}}) && (!out_valid || out_ready)) begin
          data_next_s      = mem_dout;
          valid_next_s     = 1'b1;
          last_next_s      = (remaining_r == LEN_W'(1));
          rd_ptr_next_s    = rd_ptr_r + ADDR_W'(1);
          remaining_next_s = remaining_r - LEN_W'(1);
        end else if (accept_s) begin
          valid_next_s = 1'b0;
          last_next_s  = 1'b0;
          state_next_s = DONE;
        end else begin
          state_next_s = STREAM;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_r    <= {ADDR_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
      out_data    <= {DATA_W{1'b0}};
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      rd_ptr_r    <= rd_ptr_next_s;
      remaining_r <= remaining_next_s;
      out_data    <= data_next_s;
      out_valid   <= valid_next_s;
      out_last    <= last_next_s;
      busy        <= (state_next_s == STREAM);
      done        <= (state_next_s == DONE);
    end
  end

`ifdef RD_CHECKSUM_EN
  logic [DATA_W-1:0] sum_r;
  logic [DATA_W-1:0] sum_next_s;

  assign checksum = sum_r;

  // Checksum accumulation over accepted words
  always_comb begin
    sum_next_s = sum_r;
    if (start_accept_s) begin
      sum_next_s = {DATA_W{1'b0}};
    end else if (accept_s) begin
      sum_next_s = sum_r + out_data;
    end else begin
      sum_next_s = sum_r;
    end
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_r <= {DATA_W{1'b0}};
    end else begin
      sum_r <= sum_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: a word-count model checked every cycle
// plus literal expectations of the streamed words for each directed sweep.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] length;
  logic [4:0] mem_addr;
  logic [3:0] mem_dout;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
`ifdef RD_CHECKSUM_EN
  logic [3:0] checksum;
`endif

  logic [3:0] mem [32];

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  ram_stream_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef RD_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: a sweep is n words from base; issued = words loaded so far.
  int m_active = 0, m_valid = 0, m_done = 0, m_issued = 0, m_n = 0, m_base = 0, m_sum = 0;
  int got[$];
  int last_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
  initial begin
    int acc;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid != 0) begin
          check("out_data", 32'(out_data), 32'(mem[(m_base + m_issued - 1) % 32]));
          check("out_last", 32'(out_last), 32'(m_issued == m_n));
        end
        if (m_active != 0) check("mem_addr", 32'(mem_addr), 32'((m_base + m_issued) % 32));
`ifdef RD_CHECKSUM_EN
        if (m_done != 0) check("checksum", 32'(checksum), 32'(m_sum % 16));
`endif
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
          got.push_back(int'(out_data));
          if (out_last) last_cnt++;
        end
      end
      if (!reset_n) begin
        m_active = 0; m_valid = 0; m_done = 0; m_issued = 0; m_n = 0; m_base = 0; m_sum = 0;
      end else if (m_done != 0) begin
        m_done = 0;
      end else if (m_active == 0) begin
        if (start) begin
          m_active = 1;
          m_base   = int'(base_addr);
          m_n      = (length == 6'd0) ? 32 : int'(length);
          m_issued = 0;
          m_valid  = 0;
          m_sum    = 0;
        end
      end else begin
        acc = (m_valid != 0 && out_ready) ? 1 : 0;
        if (acc != 0) m_sum += int'(mem[(m_base + m_issued - 1) % 32]);
        if (m_issued < m_n && (m_valid == 0 || out_ready)) begin
          m_issued++;
          m_valid = 1;
        end else if (acc != 0) begin
          m_valid  = 0;
          m_active = 0;
          m_done   = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got.delete();
    last_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic do_start(input int b, input int l);
    base_addr = 5'(b);
    length    = 6'(l);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic expect_got(input string name, input int exp[$]);
    check({name, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check({name, "_word"}, 32'(got[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    int exp32[$];
    for (int i = 0; i < 32; i++) mem[i] = 4'(i);
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = 5'd0;
    length    = 6'd0;
    out_ready = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic sweep
    clear_log();
    do_start(3, 4);
    wait_done(20);
    tick();
    expect_got("t1", '{3, 4, 5, 6});
    check("t1_last_cnt", 32'(last_cnt), 32'd1);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // Address wrap 31 -> 0
    clear_log();
    do_start(30, 4);
    wait_done(20);
    tick();
    expect_got("t2", '{14, 15, 0, 1});
    check("t2_ptr_after", 32'(mem_addr), 32'd2);

    // Zero length means the whole RAM
    clear_log();
    do_start(0, 0);
    wait_done(60);
    tick();
    for (int i = 0; i < 32; i++) exp32.push_back(i % 16);
    expect_got("t3", exp32);
    check("t3_last_cnt", 32'(last_cnt), 32'd1);

    // Back-pressure on the first word
    clear_log();
    out_ready = 1'b0;
    do_start(0, 3);
    for (int k = 0; k < 10 && out_valid !== 1'b1; k++) tick();
    for (int k = 0; k < 3; k++) begin
      check("t4_stall_data", 32'(out_data), 32'd0);
      check("t4_stall_addr", 32'(mem_addr), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    wait_done(20);
    tick();
    expect_got("t4", '{0, 1, 2});

    // start ignored while streaming and in DONE
    clear_log();
    do_start(8, 5);
    tick();
    base_addr = 5'd20;
    length    = 6'd2;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_done(20);
    start     = 1'b1;
    base_addr = 5'd1;
    length    = 6'd1;
    tick();
    start     = 1'b0;
    check("t5_start_in_done", 32'(busy), 32'd0);
    expect_got("t5", '{8, 9, 10, 11, 12});

    // Reset in the middle of a sweep
    clear_log();
    do_start(0, 10);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("t5r_valid", 32'(out_valid), 32'd0);
    check("t5r_busy", 32'(busy), 32'd0);
    check("t5r_data", 32'(out_data), 32'd0);
    check("t5r_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("t5r_no_done", 32'(done_cnt), 32'd0);
    clear_log();
    do_start(16, 2);
    wait_done(20);
    tick();
    expect_got("t5n", '{0, 1});

    // Random back-pressure
    clear_log();
    do_start(5, 12);
    for (int k = 0; k < 200 && done !== 1'b1; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if (done !== 1'b1) check("t7_timeout", 32'(done), 32'd1);
    out_ready = 1'b1;
    tick();
    expect_got("t7", '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0});

`ifdef RD_CHECKSUM_EN
    clear_log();
    mem[5] = 4'd9;
    mem[6] = 4'd8;
    mem[7] = 4'd7;
    do_start(5, 3);
    wait_done(20);
    check("t6_checksum", 32'(checksum), 32'd8);
    tick();
    check("t6_checksum_hold", 32'(checksum), 32'd8);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
